// File: rtl/sram_frame_loader_pkg.sv
// ---------------------------------------------------------------------------
// sram_frame_loader_pkg
// Shared widths, the loader state enum and the pixel beat payload used by
// sram_frame_loader and its pixel_packer lane register.
// ---------------------------------------------------------------------------
package sram_frame_loader_pkg;

  localparam int unsigned PIX_W        = 8;
  localparam int unsigned PIX_PER_WORD = 8;
  localparam int unsigned WORD_W       = 64;
  localparam int unsigned CNT_W        = $clog2(PIX_PER_WORD);

  // Loader control states
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOF = 2'd1,
    FILL     = 2'd2,
    DONE     = 2'd3
  } loaderState_t;

  // One pixel beat on the input stream
  typedef struct packed {
    logic             sof;
    logic [PIX_W-1:0] data;
  } pixBeat_t;

endpackage : sram_frame_loader_pkg

// File: rtl/sram_frame_loader_packer.sv
// ---------------------------------------------------------------------------
// pixel_packer
// Packs PIX_PER_WORD pixels MSB-first into one WORD_W word. Pixel k of a word
// lands in word[WORD_W-1-PIX_W*k -: PIX_W].
//
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   clear        empty the lane register and zero the byte counter
//   loadFirst    store pixIn as byte 0 of a fresh word (counter -> 1)
//   push         store pixIn in the next byte lane
//   pixIn        pixel value
//   wordDone_c   push of the last byte of a word this cycle (combinational)
//   word_c       packed word including the pixel being pushed (combinational)
// Priority: clear > loadFirst > push.
// ---------------------------------------------------------------------------
module pixel_packer
  import sram_frame_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              loadFirst,
  input  logic              push,
  input  logic [PIX_W-1:0]  pixIn,
  output logic              wordDone_c,
  output logic [WORD_W-1:0] word_c
);

  logic [CNT_W-1:0]  byteCnt;
  logic [WORD_W-1:0] laneReg;

  // Merge the incoming pixel into its lane so a completed word is available
  // in the same cycle as its last handshake.
  always_comb begin
    word_c = laneReg;
    for (int unsigned k = 0; k < PIX_PER_WORD; k++) begin
      if (push && (byteCnt == CNT_W'(k))) begin
        word_c[(PIX_PER_WORD-1-k)*PIX_W +: PIX_W] = pixIn;
      end
    end
  end

  assign wordDone_c = push && (byteCnt == CNT_W'(PIX_PER_WORD - 1));

  // Lane register and byte counter; the counter wraps naturally after the last lane
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      laneReg <= '0;
      byteCnt <= '0;
    end else if (loadFirst) begin
      laneReg <= {pixIn, {(WORD_W-PIX_W){1'b0}}};
      byteCnt <= CNT_W'(1);
    end else if (push) begin
      laneReg <= word_c;
      byteCnt <= byteCnt + CNT_W'(1);
    end
  end

endmodule : pixel_packer

// File: rtl/sram_frame_loader.sv
// ---------------------------------------------------------------------------
// sram_frame_loader
// Fills one frame of SRAM1 from an 8-bit pixel stream on request of the
// Gaussian stage. Eight pixels are packed MSB-first per 64-bit word and
// written to consecutive word addresses starting at 0. frameReady pulses once
// the whole frame is written.
//
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   getNext      fill request (level, only looked at in IDLE)
//   pix_valid    pixel present on pix_data
//   pix_data     pixel value
//   pix_sof      current pixel is the first of a frame
//   pix_ready    loader accepts a pixel this cycle
//   we1          SRAM1 write enable, one cycle per word
//   write_addr1  SRAM1 word address
//   data1        packed word
//   frameReady   one-cycle pulse after the last word is written
//   sofErr       one-cycle pulse on an SOF that arrives mid-frame
//   busy         loader is in any state other than IDLE
// All outputs are registered.
// ---------------------------------------------------------------------------
module sram_frame_loader
  import sram_frame_loader_pkg::*;
#(
  parameter int unsigned FRAME_WORDS = 524288,
  parameter int unsigned ADDR_W      = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              getNext,
  input  logic              pix_valid,
  input  logic [PIX_W-1:0]  pix_data,
  input  logic              pix_sof,
  output logic              pix_ready,
  output logic              we1,
  output logic [ADDR_W-1:0] write_addr1,
  output logic [WORD_W-1:0] data1,
  output logic              frameReady,
  output logic              sofErr,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);

  loaderState_t      state;
  loaderState_t      nextState;
  pixBeat_t          beat;
  logic              handshake;
  logic              loadFirst;
  logic              pushPix;
  logic              clearPacker;
  logic              issueWrite;
  logic              sofHit;
  logic              wordDone_c;
  logic [WORD_W-1:0] word_c;
  logic [ADDR_W-1:0] wordAddr;

  assign beat.sof  = pix_sof;
  assign beat.data = pix_data;

  assign handshake = pix_valid && pix_ready;

  // Datapath strobes; kept out of the FSM block because the packer's
  // wordDone_c depends on pushPix.
  assign loadFirst   = handshake && beat.sof && ((state == WAIT_SOF) || (state == FILL));
  assign pushPix     = handshake && !beat.sof && (state == FILL);
  assign sofHit      = handshake && beat.sof && (state == FILL);
  assign clearPacker = (state == IDLE);
  // An SOF never pushes, so a word completing under SOF is never written.
  assign issueWrite  = wordDone_c;

  pixel_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (clearPacker),
    .loadFirst  (loadFirst),
    .push       (pushPix),
    .pixIn      (beat.data),
    .wordDone_c (wordDone_c),
    .word_c     (word_c)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (getNext) begin
          nextState = WAIT_SOF;
        end
      end
      WAIT_SOF: begin
        if (loadFirst) begin
          nextState = FILL;
        end
      end
      FILL: begin
        if (issueWrite && (wordAddr == LAST_ADDR)) begin
          nextState = DONE;
        end
      end
      DONE: begin
        nextState = IDLE;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // Word address counter: restarts on every SOF, advances after each write
  always_ff @(posedge clk) begin
    if (reset || clearPacker || loadFirst) begin
      wordAddr <= '0;
    end else if (issueWrite) begin
      wordAddr <= wordAddr + ADDR_W'(1);
    end
  end

  // Output registers; ready/busy follow the state being entered
  always_ff @(posedge clk) begin
    if (reset) begin
      pix_ready   <= 1'b0;
      busy        <= 1'b0;
      we1         <= 1'b0;
      write_addr1 <= '0;
      data1       <= '0;
      frameReady  <= 1'b0;
      sofErr      <= 1'b0;
    end else begin
      pix_ready  <= (nextState == WAIT_SOF) || (nextState == FILL);
      busy       <= (nextState != IDLE);
      we1        <= issueWrite;
      frameReady <= (state == DONE);
      sofErr     <= sofHit;
      if (issueWrite) begin
        write_addr1 <= wordAddr;
        data1       <= word_c;
      end
    end
  end

endmodule : sram_frame_loader

// File: tb/tb_sram_frame_loader.sv
// ---------------------------------------------------------------------------
// tb_sram_frame_loader
// Directed bench for sram_frame_loader with FRAME_WORDS=4. Inputs change and
// outputs are sampled on the falling edge; writes, frameReady and sofErr
// pulses are logged with the cycle they appear in and compared with
// hand-derived expectations.
// ---------------------------------------------------------------------------
module tb_sram_frame_loader;

  localparam int unsigned FW = 4;
  localparam int unsigned AW = 20;

  logic          clk = 1'b0;
  logic          reset;
  logic          getNext;
  logic          pix_valid;
  logic [7:0]    pix_data;
  logic          pix_sof;
  logic          pix_ready;
  logic          we1;
  logic [AW-1:0] write_addr1;
  logic [63:0]   data1;
  logic          frameReady;
  logic          sofErr;
  logic          busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Observed events
  logic [AW-1:0] wrAddrQ[$];
  logic [63:0]   wrDataQ[$];
  int            wrCycQ[$];
  int            frCycQ[$];
  int            sofCycQ[$];

  // Expectations
  logic [AW-1:0] expAddrQ[$];
  logic [63:0]   expDataQ[$];
  int            expCycQ[$];
  bit            inFrame;
  int            wordPos;
  int            lastHsCyc;

  sram_frame_loader #(
    .FRAME_WORDS (FW),
    .ADDR_W      (AW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .getNext     (getNext),
    .pix_valid   (pix_valid),
    .pix_data    (pix_data),
    .pix_sof     (pix_sof),
    .pix_ready   (pix_ready),
    .we1         (we1),
    .write_addr1 (write_addr1),
    .data1       (data1),
    .frameReady  (frameReady),
    .sofErr      (sofErr),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (we1 === 1'b1) begin
      wrAddrQ.push_back(write_addr1);
      wrDataQ.push_back(data1);
      wrCycQ.push_back(cyc);
    end
    if (frameReady === 1'b1) frCycQ.push_back(cyc);
    if (sofErr === 1'b1) sofCycQ.push_back(cyc);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] expWord(input int base);
    logic [63:0] w;
    w = '0;
    for (int j = 0; j < 8; j++) w = {w[55:0], 8'(base + j)};
    return w;
  endfunction

  task automatic clearLogs();
    wrAddrQ.delete(); wrDataQ.delete(); wrCycQ.delete();
    frCycQ.delete(); sofCycQ.delete();
    expAddrQ.delete(); expDataQ.delete(); expCycQ.delete();
    inFrame = 1'b0;
    wordPos = 0;
  endtask

  task automatic expectWrite(input int addr, input int base);
    expAddrQ.push_back(AW'(addr));
    expDataQ.push_back(expWord(base));
  endtask

  // Present one pixel and hold it until it is accepted (bounded wait).
  // A handshake lands on the rising edge after the falling edge where
  // pix_ready is seen high; its registered write appears in that cycle.
  task automatic pushPix(input logic [7:0] d, input logic s);
    int w;
    @(negedge clk);
    pix_valid = 1'b1;
    pix_data  = d;
    pix_sof   = s;
    w = 0;
    while (!pix_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!pix_ready) begin
      checkVal("readyTimeout", 64'(pix_ready), 64'd1);
    end else begin
      lastHsCyc = cyc + 1;
      if (s) begin
        inFrame = 1'b1;
        wordPos = 0;
      end
      if (inFrame) begin
        if (wordPos == 7) expCycQ.push_back(cyc + 1);
        wordPos = (wordPos + 1) % 8;
      end
    end
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(negedge clk);
      pix_valid = 1'b0;
      pix_sof   = 1'b0;
    end
  endtask

  task automatic sendRun(input int base, input int n, input bit sofFirst, input bit gaps);
    for (int i = 0; i < n; i++) begin
      pushPix(8'(base + i), sofFirst && (i == 0));
      if (gaps && (i % 5 == 2)) idleCycles((i % 3) + 1);
    end
  endtask

  task automatic pulseGetNext();
    @(negedge clk);
    getNext = 1'b1;
    @(negedge clk);
    getNext = 1'b0;
  endtask

  task automatic verifyWrites(input string tag, input int nFr);
    checkVal({tag, ".writes"}, 64'(wrAddrQ.size()), 64'(expAddrQ.size()));
    for (int i = 0; i < expAddrQ.size(); i++) begin
      if (i < wrAddrQ.size()) begin
        checkVal($sformatf("%s.addr%0d", tag, i), 64'(wrAddrQ[i]), 64'(expAddrQ[i]));
        checkVal($sformatf("%s.data%0d", tag, i), wrDataQ[i], expDataQ[i]);
        if (i < expCycQ.size())
          checkVal($sformatf("%s.wrCyc%0d", tag, i), 64'(wrCycQ[i]), 64'(expCycQ[i]));
      end
    end
    checkVal({tag, ".frameReadyCnt"}, 64'(frCycQ.size()), 64'(nFr));
    if (frCycQ.size() > 0 && expCycQ.size() > 0)
      checkVal({tag, ".frameReadyCyc"}, 64'(frCycQ[0]), 64'(expCycQ[expCycQ.size()-1] + 1));
  endtask

  task automatic checkResetOutputs(input string tag);
    checkVal({tag, ".pix_ready"},   64'(pix_ready),   64'd0);
    checkVal({tag, ".we1"},         64'(we1),         64'd0);
    checkVal({tag, ".write_addr1"}, 64'(write_addr1), 64'd0);
    checkVal({tag, ".data1"},       data1,            64'd0);
    checkVal({tag, ".frameReady"},  64'(frameReady),  64'd0);
    checkVal({tag, ".sofErr"},      64'(sofErr),      64'd0);
    checkVal({tag, ".busy"},        64'(busy),        64'd0);
  endtask

  initial begin
    reset     = 1'b1;
    getNext   = 1'b0;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    pix_data  = 8'h00;
    lastHsCyc = 0;
    clearLogs();
    repeat (2) @(negedge clk);
    checkResetOutputs("reset");
    reset = 1'b0;

    // Basic back-to-back fill
    clearLogs();
    pulseGetNext();
    checkVal("basic.busyAfterReq", 64'(busy), 64'd1);
    checkVal("basic.readyAfterReq", 64'(pix_ready), 64'd1);
    sendRun(8'h00, 32, 1'b1, 1'b0);
    idleCycles(4);
    for (int i = 0; i < 4; i++) expectWrite(i, 8 * i);
    verifyWrites("basic", 1);
    checkVal("basic.readyAfter", 64'(pix_ready), 64'd0);
    checkVal("basic.busyAfter", 64'(busy), 64'd0);
    checkVal("basic.sofErrCnt", 64'(sofCycQ.size()), 64'd0);

    // Pixels before SOF are dropped
    clearLogs();
    pulseGetNext();
    pushPix(8'hAA, 1'b0);
    pushPix(8'hBB, 1'b0);
    sendRun(8'h00, 32, 1'b1, 1'b0);
    idleCycles(4);
    for (int i = 0; i < 4; i++) expectWrite(i, 8 * i);
    verifyWrites("discard", 1);
    checkVal("discard.sofErrCnt", 64'(sofCycQ.size()), 64'd0);

    // Valid bubbles
    clearLogs();
    pulseGetNext();
    sendRun(8'h00, 32, 1'b1, 1'b1);
    idleCycles(4);
    for (int i = 0; i < 4; i++) expectWrite(i, 8 * i);
    verifyWrites("bubbles", 1);

    // SOF mid-frame after 11 pixels restarts the frame
    clearLogs();
    pulseGetNext();
    sendRun(8'h00, 11, 1'b1, 1'b0);
    pushPix(8'h40, 1'b1);
    begin : sofMark
      int sofHsCyc;
      sofHsCyc = lastHsCyc;
      sendRun(8'h41, 31, 1'b0, 1'b0);
      idleCycles(4);
      expectWrite(0, 8'h00);
      for (int i = 0; i < 4; i++) expectWrite(i, 8'h40 + 8 * i);
      verifyWrites("midSof", 1);
      checkVal("midSof.sofErrCnt", 64'(sofCycQ.size()), 64'd1);
      if (sofCycQ.size() > 0)
        checkVal("midSof.sofErrCyc", 64'(sofCycQ[0]), 64'(sofHsCyc));
    end

    // Reset after 13 pixels, then a clean fill
    clearLogs();
    pulseGetNext();
    sendRun(8'h20, 13, 1'b1, 1'b0);
    @(negedge clk);
    reset     = 1'b1;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    @(negedge clk);
    checkResetOutputs("midReset");
    reset   = 1'b0;
    inFrame = 1'b0;
    idleCycles(10);
    checkVal("midReset.noWrite", 64'(wrAddrQ.size()), 64'd1);
    pulseGetNext();
    sendRun(8'h80, 32, 1'b1, 1'b0);
    idleCycles(4);
    expectWrite(0, 8'h20);
    for (int i = 0; i < 4; i++) expectWrite(i, 8'h80 + 8 * i);
    verifyWrites("midReset", 1);

    // IDLE refuses pixels
    clearLogs();
    @(negedge clk);
    pix_valid = 1'b1;
    pix_data  = 8'h77;
    pix_sof   = 1'b1;
    repeat (5) @(negedge clk);
    checkVal("idle.ready", 64'(pix_ready), 64'd0);
    checkVal("idle.busy", 64'(busy), 64'd0);
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    idleCycles(2);
    checkVal("idle.writes", 64'(wrAddrQ.size()), 64'd0);

    // getNext held high through FILL and DONE
    @(negedge clk);
    getNext = 1'b1;
    sendRun(8'h60, 32, 1'b1, 1'b0);
    begin : waitFr
      int w;
      w = 0;
      @(negedge clk);
      pix_valid = 1'b0;
      pix_sof   = 1'b0;
      while (frameReady !== 1'b1 && w < 10) begin
        @(negedge clk);
        w++;
      end
      checkVal("hold.frameReadySeen", 64'(frameReady), 64'd1);
    end
    @(negedge clk);
    checkVal("hold.busyRestart", 64'(busy), 64'd1);
    checkVal("hold.readyRestart", 64'(pix_ready), 64'd1);
    getNext = 1'b0;
    for (int i = 0; i < 4; i++) expectWrite(i, 8'h60 + 8 * i);
    verifyWrites("hold", 1);

    // The restarted fill completes normally
    clearLogs();
    sendRun(8'hC0, 32, 1'b1, 1'b0);
    idleCycles(4);
    for (int i = 0; i < 4; i++) expectWrite(i, 8'hC0 + 8 * i);
    verifyWrites("refill", 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_sram_frame_loader

// File: doc/sram_frame_loader.md
# sram_frame_loader

Upstream feeder for the Gaussian stage. Accepts an 8-bit pixel stream over a valid/ready handshake, packs eight pixels per 64-bit word and writes a full frame into SRAM1 through the SRAM1 write port. A fill starts on the `getNext` request from the Gaussian stage. On completion the block pulses `frameReady`, which drives the Gaussian stage `startEn`.

## Interface
- `FRAME_WORDS`, 524288: 64-bit words per frame; must be ≥ 1 and ≤ 2^20.
- `ADDR_W`, 20: SRAM1 address width.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high.
- `getNext`  in  1  fill request from the Gaussian stage; level, sampled only in IDLE.
- `pix_valid`  in  1  pixel present on `pix_data`.
- `pix_data`  in  8  pixel value.
- `pix_sof`  in  1  qualifies the current pixel as the first of a frame.
- `pix_ready`  out  1  loader accepts a pixel this cycle.
- `we1`  out  1  SRAM1 write enable, one cycle per word.
- `write_addr1`  out  ADDR_W  SRAM1 word address.
- `data1`  out  64  packed word.
- `frameReady`  out  1  one-cycle pulse after the last word is written.
- `sofErr`  out  1  one-cycle pulse on an unexpected SOF mid-frame.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- A pixel handshake occurs when `pix_valid && pix_ready`.
- States and transitions:
  - IDLE: `pix_ready`=0. If `getNext`=1, go to WAIT_SOF.
  - WAIT_SOF: `pix_ready`=1. Handshaked pixels without `pix_sof` are discarded. A handshake with `pix_sof`=1 loads that pixel as byte 0 of word 0, then go to FILL.
  - FILL: `pix_ready`=1. Each handshake stores the pixel in the next byte lane. When the 8th byte of a word is accepted, the word is issued as a write. When word FRAME_WORDS-1 is issued, go to DONE. Go to DONE from the cycle after that handshake, and deassert `pix_ready` from then on.
  - DONE: lasts one cycle. `frameReady`=1, then go to IDLE.
- Packing is MSB-first:
  - pixel k of a word goes to `data1[63-8k -: 8]`.
  - So the first pixel occupies bits [63:56].
- Address starts at 0 for each frame and increments by 1 after each write. It never wraps inside a frame.
- SOF during FILL:
  - `sofErr` pulses.
  - Byte count and address reset to 0, and the SOF pixel becomes byte 0 of word 0.
  - A word completed in the same cycle is not written.
- `getNext` outside IDLE is ignored. `getNext` held high through DONE starts a new fill immediately from IDLE.
- `pix_valid` gaps are allowed anywhere. A partial word is held indefinitely.
- Reset in any state:
  - next cycle the block is in IDLE.
  - all counters are 0.
  - no write is issued for a partial word.

## Timing
- Reset values: `pix_ready`=0, `we1`=0, `write_addr1`=0, `data1`=0, `frameReady`=0, `sofErr`=0, `busy`=0.
- Write latency: `we1`, `write_addr1` and `data1` are registered and valid the cycle after the 8th pixel handshake. `we1` is high for exactly one cycle.
- `data1` and `write_addr1` hold their values between writes.
- Maximum throughput is one pixel per cycle, giving at most one write every 8 cycles. No backpressure from SRAM1.
- `frameReady` is asserted the cycle after the final `we1`.
- `sofErr` is asserted the cycle after the offending handshake.
- `busy` is asserted the cycle after `getNext` is sampled in IDLE and deasserts the cycle after DONE.

## Structure
- Shared package contains:
  - `PIX_W`=8.
  - `PIX_PER_WORD`=8.
  - `WORD_W`=64.
  - the state enum {IDLE, WAIT_SOF, FILL, DONE}.
- Sub-module `pixel_packer`:
  - 8→64 lane register with a 3-bit byte counter.
  - inputs: clear, load-as-first, push.
  - outputs: `word_done` pulse and the packed word.
- The top level holds the FSM, address counter and output registers.

## Test plan
- Basic fill, FRAME_WORDS=4: pulse `getNext`, then stream 0x00..0x1F back-to-back with SOF on 0x00.
  - Expect writes to addr 0..3 with data 0x0001020304050607, 0x08090A0B0C0D0E0F, 0x1011121314151617, 0x18191A1B1C1D1E1F.
  - Expect `frameReady` one cycle after the 4th write, then `pix_ready`=0.
- Pre-SOF discard: in WAIT_SOF, send 0xAA, 0xBB without SOF, then frame 0x00..0x1F.
  - Expect an identical write sequence and no `sofErr`.
- Bubbles: insert random `pix_valid`=0 gaps.
  - Expect the same four words and addresses.
  - Expect each `we1` exactly one cycle after its 8th handshake.
- SOF mid-frame: after 11 pixels, send SOF with 0x40 followed by 0x41..0x5F.
  - Expect `sofErr` pulse.
  - Expect next write at addr 0 = 0x4041424344454647, with 4 writes total after the restart.
- Reset mid-fill: assert reset after 13 pixels.
  - Expect all outputs at reset values next cycle and no further `we1`.
  - A new `getNext` then performs a full clean fill.
- Request handling:
  - `getNext` asserted during FILL has no effect.
  - `getNext` held high through DONE starts the next fill.
  - `pix_ready`=0 in IDLE with `pix_valid`=1 accepts nothing.
